// File: rtl/sobel_pkg.sv
// Shared width constants for the Sobel datapath.
// Sizes pixel and gradient-magnitude buses at instantiation sites.
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 16;

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit ripple adder built from chained full_add cells.
// Purely combinational; carry ripples LSB to MSB.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o
);

    // Per-bit carry lives in its own generate scope so the ripple is not a self-loop on one vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = c_i;
        end else begin : g_next
            assign c_in = g_bit[i-1].c_out;
        end

        full_add u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c_in),
            .s_o (sum_o[i]),
            .c_o (c_out)
        );
    end

    assign c_o = g_bit[CHUNK-1].c_out;

endmodule

// File: rtl/full_add.sv
// Single-bit full adder cell, purely combinational.
// No state, no handshake.
module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit adder, one ripple chunk per stage; latency STAGES cycles, 1 result/cycle.
// Valid/ready with a combinational ready chain; empty stages load even while downstream stalls.
module pipe_add import sobel_pkg::*; #(
    parameter int WIDTH  = GRAD_W,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $fatal(1, "pipe_add: WIDTH must be a multiple of STAGES");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES:0]   en;

    // A stage may load when it is empty or when the stage after it is moving.
    always_comb begin
        en         = '0;
        en[STAGES] = ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en[k] = !vld[k] || en[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int REM = WIDTH - k * CHUNK;
        localparam int SW  = (k + 1) * CHUNK;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_c;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign a_in  = a_i;
            assign b_in  = b_i;
            assign c_in  = cin_i;
            assign v_in  = valid_i;
            assign sum_d = chunk_sum;
        end else begin : g_link
            assign a_in  = g_st[k-1].g_skew.a_q;
            assign b_in  = g_st[k-1].g_skew.b_q;
            assign c_in  = g_st[k-1].c_q;
            assign v_in  = g_st[k-1].v_q;
            assign sum_d = {chunk_sum, g_st[k-1].sum_q};
        end

        add_chunk #(.CHUNK(CHUNK)) u_add (
            .a_i   (a_in[CHUNK-1:0]),
            .b_i   (b_in[CHUNK-1:0]),
            .c_i   (c_in),
            .sum_o (chunk_sum),
            .c_o   (chunk_c)
        );

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (en[k]) begin
                v_q <= v_in;
                if (v_in) begin
                    sum_q <= sum_d;
                    c_q   <= chunk_c;
                end
            end
        end

        // Operand bits not yet summed ride along with the token.
        if (REM > CHUNK) begin : g_skew
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en[k] && v_in) begin
                    a_q <= a_in[REM-1:CHUNK];
                    b_q <= b_in[REM-1:CHUNK];
                end
            end
        end

        assign vld[k] = v_q;
    end

    assign ready_o = en[0];
    assign valid_o = vld[STAGES-1];
    assign sum_o   = g_st[STAGES-1].sum_q;
    assign carry_o = g_st[STAGES-1].c_q;

endmodule

// File: tb/tb_pipe_add.sv
// Directed bench for pipe_add (16b/4 stages) plus an exhaustive 4b/2 stage instance.
// Expected sums come from a scoreboard queue filled at each accepted input.
module tb_pipe_add;

    logic        clk;
    logic        rst;

    logic        valid_i, ready_o, valid_o, ready_i, cin_i, carry_o;
    logic [15:0] a_i, b_i, sum_o;

    logic        s_valid_i, s_ready_o, s_valid_o, s_ready_i, s_cin_i, s_carry_o;
    logic [3:0]  s_a_i, s_b_i, s_sum_o;

    pipe_add #(.WIDTH(16), .STAGES(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .carry_o (carry_o)
    );

    pipe_add #(.WIDTH(4), .STAGES(2)) dut_small (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (s_valid_i),
        .ready_o (s_ready_o),
        .a_i     (s_a_i),
        .b_i     (s_b_i),
        .cin_i   (s_cin_i),
        .valid_o (s_valid_o),
        .ready_i (s_ready_i),
        .sum_o   (s_sum_o),
        .carry_o (s_carry_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [16:0] exp_q[$];
    logic [4:0]  exp2_q[$];
    logic        acc, acc2;
    logic        stall_hold;
    logic [16:0] held;
    logic        saw_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        acc  = 1'b0;
        acc2 = 1'b0;
        if (!rst) begin
            if (stall_hold) begin
                check("stall_hold", {15'd0, carry_o, sum_o}, {15'd0, held});
                check("stall_vld", {31'd0, valid_o}, 32'd1);
            end
            stall_hold = valid_o && !ready_i;
            held       = {carry_o, sum_o};
            if (!ready_o) saw_full = 1'b1;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
                else check("sum", {15'd0, carry_o, sum_o}, {15'd0, exp_q.pop_front()});
            end
            if (valid_i && ready_o) begin
                exp_q.push_back({1'b0, a_i} + {1'b0, b_i} + 17'(cin_i));
                acc = 1'b1;
            end
            if (s_valid_o && s_ready_i) begin
                if (exp2_q.size() == 0) check("small_spurious", 32'(exp2_q.size()), 32'd1);
                else check("small_sum", {27'd0, s_carry_o, s_sum_o}, {27'd0, exp2_q.pop_front()});
            end
            if (s_valid_i && s_ready_o) begin
                exp2_q.push_back({1'b0, s_a_i} + {1'b0, s_b_i} + 5'(s_cin_i));
                acc2 = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ready_i   = 1'b1;
        s_ready_i = 1'b1;
        valid_i   = 1'b0;
        s_valid_i = 1'b0;
        for (int n = 0; n < 64 && (exp_q.size() != 0 || exp2_q.size() != 0); n++) cycle();
        check("drain_big", 32'(exp_q.size()), 32'd0);
        check("drain_small", 32'(exp2_q.size()), 32'd0);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        cin_i   = c;
        cycle();
        valid_i = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        stall_hold = 1'b0; held = '0; saw_full = 1'b0; acc = 1'b0; acc2 = 1'b0;
        rst = 1'b1;
        valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0; cin_i = 1'b0;
        s_valid_i = 1'b0; s_ready_i = 1'b1; s_a_i = '0; s_b_i = '0; s_cin_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_sum", {15'd0, carry_o, sum_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_small_valid", {31'd0, s_valid_o}, 32'd0);
        rst = 1'b0;

        // 1: single token, latency 4
        send(16'h1234, 16'h0F0F, 1'b0);
        cycle(); cycle();
        check("lat_early", {31'd0, valid_o}, 32'd0);
        cycle();
        check("lat_valid", {31'd0, valid_o}, 32'd1);
        check("lat_sum", {15'd0, carry_o, sum_o}, 32'h02143);
        cycle();
        check("lat_after", {31'd0, valid_o}, 32'd0);

        // 2: carry across every chunk, back-to-back
        valid_i = 1'b1; a_i = 16'hFFFF; b_i = 16'h0001; cin_i = 1'b0;
        cycle();
        a_i = 16'h8000; b_i = 16'h8000; cin_i = 1'b1;
        cycle();
        valid_i = 1'b0;
        cycle(); cycle();
        check("wrap_first", {14'd0, valid_o, carry_o, sum_o}, 32'h30000);
        cycle();
        check("wrap_second", {14'd0, valid_o, carry_o, sum_o}, 32'h30001);
        drain();

        // 3: 8 tokens with a 3-cycle downstream stall
        saw_full = 1'b0;
        begin
            int idx = 0;
            for (int c = 0; c < 40 && idx < 8; c++) begin
                ready_i = !(c >= 4 && c <= 6);
                valid_i = 1'b1;
                a_i     = 16'($urandom);
                b_i     = 16'($urandom);
                cin_i   = 1'($urandom);
                cycle();
                if (acc) idx++;
            end
            check("stream_count", 32'(idx), 32'd8);
        end
        check("stream_full", {31'd0, saw_full}, 32'd1);
        drain();

        // 4: bubble collapse while downstream stalled
        ready_i = 1'b0;
        send(16'h0102, 16'h0304, 1'b1);
        cycle(); cycle();
        valid_i = 1'b1; a_i = 16'hA000; b_i = 16'h7000; cin_i = 1'b0;
        #1;
        check("bubble_ready", {31'd0, ready_o}, 32'd1);
        cycle();
        check("bubble_acc", {31'd0, acc}, 32'd1);
        valid_i = 1'b0;
        cycle(); cycle();
        ready_i = 1'b1;
        #1;
        check("bubble_emit1", {31'd0, valid_o}, 32'd1);
        cycle();
        check("bubble_emit2", {31'd0, valid_o}, 32'd1);
        cycle();
        check("bubble_done", {31'd0, valid_o}, 32'd0);
        drain();

        // 5: reset with 3 tokens in flight
        for (int i = 0; i < 3; i++) send(16'(i * 16'h1111 + 16'h0101), 16'h2222, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_sum", {15'd0, carry_o, sum_o}, 32'd0);
        exp_q.delete();
        stall_hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("midrst_quiet", {31'd0, valid_o}, 32'd0);
        end

        // 6: exhaustive 4-bit, 2-stage with random backpressure
        begin
            int guard = 0;
            for (int x = 0; x < 512 && guard < 5000; x++) begin
                s_valid_i = 1'b1;
                s_a_i     = 4'(x);
                s_b_i     = 4'(x >> 4);
                s_cin_i   = 1'(x >> 8);
                do begin
                    s_ready_i = ($urandom_range(0, 3) != 0);
                    cycle();
                    guard++;
                end while (!acc2 && guard < 5000);
            end
            check("exh_budget", {31'd0, guard < 5000}, 32'd1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
